// File: rtl/mem_pkg.sv
// Shared memory-operation types for the BRAM client front end.
// A request/response is {byte_en, addr, data}; an all-zero byte_en marks a read.
package mem_pkg;

    localparam int REQ_ADDR_WIDTH = 32;
    localparam int REQ_DATA_WIDTH = 32;
    localparam int MEM_OP_SIZE    = 4 + REQ_ADDR_WIDTH + REQ_DATA_WIDTH;

    typedef struct packed {
        logic [3:0]                byte_en;
        logic [REQ_ADDR_WIDTH-1:0] addr;
        logic [REQ_DATA_WIDTH-1:0] data;
    } mem_op_t;

    typedef logic client_id_t;

    function automatic logic is_read(input mem_op_t op);
        return op.byte_en == 4'b0000;
    endfunction

endpackage

// File: rtl/id_fifo.sv
// DEPTH x 1-bit synchronous FIFO holding the client ID of each read in flight.
// Push while full and pop while empty are ignored.
module id_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     din,
    output logic                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] slots;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = slots[rd_ptr];

    // Pointers are exactly AW bits wide, so they wrap on their own.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            slots  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= din;
                wr_ptr        <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_client_arbiter.sv
// Two-client round-robin front end for the single-port BRAM model; read
// responses are steered back to their issuer in order via an ID FIFO.
module mem_client_arbiter
    import mem_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int OP_WIDTH = MEM_OP_SIZE
) (
    input  logic                   CLK,
    input  logic                   RST,

    input  logic                   c0_req_valid,
    output logic                   c0_req_ready,
    input  logic [OP_WIDTH-1:0]    c0_req,
    output logic                   c0_resp_valid,
    input  logic                   c0_resp_ready,
    output logic [OP_WIDTH-1:0]    c0_resp,

    input  logic                   c1_req_valid,
    output logic                   c1_req_ready,
    input  logic [OP_WIDTH-1:0]    c1_req,
    output logic                   c1_resp_valid,
    input  logic                   c1_resp_ready,
    output logic [OP_WIDTH-1:0]    c1_resp,

    output logic                   mem_put_valid,
    input  logic                   mem_put_ready,
    output logic [OP_WIDTH-1:0]    mem_put_request,
    input  logic                   mem_get_ready,
    output logic                   mem_get_valid,
    input  logic [OP_WIDTH-1:0]    mem_get_response,

    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   err_orphan
);

    mem_op_t    c0_op;
    mem_op_t    c1_op;
    mem_op_t    win_op;
    logic       c0_elig;
    logic       c1_elig;
    logic       grant_any;
    client_id_t grant_id;
    client_id_t last_grant;
    client_id_t head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       put_fire;
    logic       fifo_push;
    logic       fifo_pop;

    assign c0_op = mem_op_t'(c0_req);
    assign c1_op = mem_op_t'(c1_req);

    // Writes never need a FIFO slot, so only reads stall on a full FIFO.
    assign c0_elig = c0_req_valid && (!is_read(c0_op) || !fifo_full);
    assign c1_elig = c1_req_valid && (!is_read(c1_op) || !fifo_full);

    always_comb begin
        grant_any = c0_elig || c1_elig;
        grant_id  = 1'b0;
        if (c0_elig && c1_elig) begin
            grant_id = !last_grant;
        end else if (c1_elig) begin
            grant_id = 1'b1;
        end
    end

    assign win_op          = grant_id ? c1_op : c0_op;
    assign mem_put_valid   = !RST && grant_any;
    assign mem_put_request = mem_put_valid ? win_op : '0;
    assign c0_req_ready    = mem_put_valid && mem_put_ready && !grant_id;
    assign c1_req_ready    = mem_put_valid && mem_put_ready && grant_id;
    assign put_fire        = mem_put_valid && mem_put_ready;
    assign fifo_push       = put_fire && is_read(win_op);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_grant <= 1'b1;
        end else if (put_fire) begin
            last_grant <= grant_id;
        end
    end

    assign c0_resp_valid = !RST && mem_get_ready && !fifo_empty && !head;
    assign c1_resp_valid = !RST && mem_get_ready && !fifo_empty && head;
    assign c0_resp       = mem_get_response;
    assign c1_resp       = mem_get_response;
    assign mem_get_valid = !RST && !fifo_empty && (head ? c1_resp_ready : c0_resp_ready);
    assign fifo_pop      = mem_get_ready && mem_get_valid;

    // A response with nothing outstanding means the memory and this block disagree.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_orphan <= 1'b0;
        end else if (mem_get_ready && fifo_empty) begin
            err_orphan <= 1'b1;
        end
    end

    id_fifo #(
        .DEPTH (DEPTH)
    ) u_id_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (grant_id),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outstanding)
    );

endmodule

// File: tb/tb_mem_client_arbiter.sv
// Bench for mem_client_arbiter: client drivers, a BRAM model answering one
// cycle after a read, and a scoreboard of expected responses in issue order.
module tb_mem_client_arbiter;

    localparam int DEPTH = 4;
    localparam int OW    = 68;

    typedef struct {
        logic          id;
        logic [OW-1:0] op;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          c0_req_valid, c0_req_ready, c0_resp_valid, c0_resp_ready;
    logic [OW-1:0] c0_req, c0_resp;
    logic          c1_req_valid, c1_req_ready, c1_resp_valid, c1_resp_ready;
    logic [OW-1:0] c1_req, c1_resp;
    logic          mem_put_valid, mem_put_ready, mem_get_ready, mem_get_valid;
    logic [OW-1:0] mem_put_request, mem_get_response;
    logic [2:0]    outstanding;
    logic          err_orphan;

    exp_t          exp_q[$];
    logic [OW-1:0] c0_q[$];
    logic [OW-1:0] c1_q[$];
    logic [OW-1:0] mem_q[$];
    logic          grant_log[$];
    logic [31:0]   mem_arr [logic [31:0]];

    int            tests_run = 0;
    int            tests_failed = 0;
    logic          c0_acc_s = 1'b0, c1_acc_s = 1'b0;
    logic          put_fire_s = 1'b0, get_fire_s = 1'b0;
    logic [OW-1:0] put_req_s = '0;
    logic          force_orphan = 1'b0;
    int            c1_wr_acc = 0, c1_rv_cnt = 0, max_out = 0;
    logic [31:0]   wtmp;
    logic [OW-1:0] dummy;

    always #5 CLK = ~CLK;

    mem_client_arbiter #(.DEPTH(DEPTH), .OP_WIDTH(OW)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .c0_req_valid     (c0_req_valid),
        .c0_req_ready     (c0_req_ready),
        .c0_req           (c0_req),
        .c0_resp_valid    (c0_resp_valid),
        .c0_resp_ready    (c0_resp_ready),
        .c0_resp          (c0_resp),
        .c1_req_valid     (c1_req_valid),
        .c1_req_ready     (c1_req_ready),
        .c1_req           (c1_req),
        .c1_resp_valid    (c1_resp_valid),
        .c1_resp_ready    (c1_resp_ready),
        .c1_resp          (c1_resp),
        .mem_put_valid    (mem_put_valid),
        .mem_put_ready    (mem_put_ready),
        .mem_put_request  (mem_put_request),
        .mem_get_ready    (mem_get_ready),
        .mem_get_valid    (mem_get_valid),
        .mem_get_response (mem_get_response),
        .outstanding      (outstanding),
        .err_orphan       (err_orphan)
    );

    task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic bench_idle();
        return c0_q.size() == 0 && c1_q.size() == 0 && exp_q.size() == 0 &&
               mem_q.size() == 0 && outstanding == 3'd0;
    endfunction

    task automatic resp_chk(input logic id, input logic vld, input logic rdy, input logic [OW-1:0] data);
        if (exp_q.size() == 0) begin
            chk(id ? "resp_unexpected_c1" : "resp_unexpected_c0", OW'(vld), '0);
        end else begin
            chk("resp_route", OW'(id), OW'(exp_q[0].id));
            if (rdy) begin
                chk(id ? "resp_data_c1" : "resp_data_c0", data, exp_q[0].op);
                void'(exp_q.pop_front());
            end
        end
    endtask

    // Sample everything mid-cycle; the values seen here are what the next edge acts on.
    always @(negedge CLK) begin
        c0_acc_s   = !RST && c0_req_valid && c0_req_ready;
        c1_acc_s   = !RST && c1_req_valid && c1_req_ready;
        put_fire_s = !RST && mem_put_valid && mem_put_ready;
        put_req_s  = mem_put_request;
        get_fire_s = !RST && mem_get_ready && mem_get_valid;
        if (!RST) begin
            if (c0_acc_s) begin
                grant_log.push_back(1'b0);
                if (c0_req[67:64] == 4'b0000)
                    exp_q.push_back('{1'b0, {4'b0000, c0_req[63:32], mem_rd(c0_req[63:32])}});
            end
            if (c1_acc_s) begin
                grant_log.push_back(1'b1);
                if (c1_req[67:64] == 4'b0000)
                    exp_q.push_back('{1'b1, {4'b0000, c1_req[63:32], mem_rd(c1_req[63:32])}});
                else
                    c1_wr_acc++;
            end
            if (c1_resp_valid) c1_rv_cnt++;
            if (int'(outstanding) > max_out) max_out = int'(outstanding);
            if (c0_resp_valid) resp_chk(1'b0, c0_resp_valid, c0_resp_ready, c0_resp);
            if (c1_resp_valid) resp_chk(1'b1, c1_resp_valid, c1_resp_ready, c1_resp);
        end
    end

    // Client drivers and BRAM model: update just after the rising edge.
    always @(posedge CLK) begin
        #1;
        if (RST) begin
            mem_q.delete();
        end else begin
            if (get_fire_s && mem_q.size() > 0) dummy = mem_q.pop_front();
            if (put_fire_s) begin
                if (put_req_s[67:64] == 4'b0000) begin
                    mem_q.push_back({4'b0000, put_req_s[63:32], mem_rd(put_req_s[63:32])});
                end else begin
                    wtmp = mem_rd(put_req_s[63:32]);
                    for (int b = 0; b < 4; b++)
                        if (put_req_s[64+b]) wtmp[8*b +: 8] = put_req_s[8*b +: 8];
                    mem_arr[put_req_s[63:32]] = wtmp;
                end
            end
        end
        if (c0_acc_s && c0_q.size() > 0) dummy = c0_q.pop_front();
        if (c1_acc_s && c1_q.size() > 0) dummy = c1_q.pop_front();
        c0_req_valid     = c0_q.size() > 0;
        c0_req           = c0_req_valid ? c0_q[0] : '0;
        c1_req_valid     = c1_q.size() > 0;
        c1_req           = c1_req_valid ? c1_q[0] : '0;
        mem_get_ready    = force_orphan || mem_q.size() > 0;
        mem_get_response = mem_q.size() > 0 ? mem_q[0] : '0;
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic rd(input logic cl, input logic [31:0] a);
        if (cl) c1_q.push_back({4'b0000, a, 32'h0});
        else    c0_q.push_back({4'b0000, a, 32'h0});
    endtask

    task automatic wr(input logic cl, input logic [31:0] a, input logic [31:0] d);
        if (cl) c1_q.push_back({4'b1111, a, d});
        else    c0_q.push_back({4'b1111, a, d});
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!bench_idle() && k < 300);
        chk(tag, OW'(bench_idle()), OW'(1));
    endtask

    task automatic wait_out(input int n, input string tag);
        int k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (int'(outstanding) != n && k < 100);
        chk(tag, OW'(outstanding), OW'(n));
    endtask

    task automatic rst_pulse();
        step();
        RST = 1'b1;
        c0_q.delete();
        c1_q.delete();
        exp_q.delete();
        repeat (2) step();
        RST = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        RST = 1'b1;
        c0_req_valid = 1'b0; c0_req = '0; c0_resp_ready = 1'b1;
        c1_req_valid = 1'b0; c1_req = '0; c1_resp_ready = 1'b1;
        mem_put_ready = 1'b1; mem_get_ready = 1'b0; mem_get_response = '0;
        mem_arr[32'h100] = 32'hDEAD_BEEF;

        #1;
        chk("rst_outstanding", OW'(outstanding), '0);
        chk("rst_err_orphan", OW'(err_orphan), '0);
        chk("rst_put_valid", OW'(mem_put_valid), '0);
        repeat (3) step();
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_put_request", mem_put_request, '0);
        chk("post_rst_get_valid", OW'(mem_get_valid), '0);
        chk("post_rst_resp_valid", OW'({c0_resp_valid, c1_resp_valid}), '0);
        chk("post_rst_outstanding", OW'(outstanding), '0);

        // Single read returning DEADBEEF to client 0.
        rd(1'b0, 32'h100);
        k = 0;
        do begin @(negedge CLK); k++; end while (!c0_req_ready && k < 20);
        chk("t1_accept", OW'(c0_req_ready), OW'(1));
        chk("t1_out_before", OW'(outstanding), '0);
        @(negedge CLK);
        chk("t1_out_inflight", OW'(outstanding), OW'(1));
        chk("t1_c0_resp_valid", OW'(c0_resp_valid), OW'(1));
        chk("t1_c0_resp_data", OW'(c0_resp[31:0]), OW'(32'hDEAD_BEEF));
        chk("t1_c1_resp_valid", OW'(c1_resp_valid), '0);
        @(negedge CLK);
        chk("t1_out_after", OW'(outstanding), '0);
        wait_idle("t1_idle");

        // Contention from reset: grants must alternate starting with client 0.
        rst_pulse();
        grant_log.delete();
        for (int i = 0; i < 4; i++) begin
            rd(1'b0, 32'h200 + 32'(4*i));
            rd(1'b1, 32'h300 + 32'(4*i));
        end
        wait_idle("t2_idle");
        chk("t2_grant_count", OW'(grant_log.size()), OW'(8));
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            chk("t2_grant_order", OW'(grant_log[i]), OW'(i % 2));

        // Writes take no FIFO slot.
        c1_wr_acc = 0; c1_rv_cnt = 0; max_out = 0;
        for (int i = 0; i < 6; i++) wr(1'b1, 32'h400 + 32'(4*i), 32'h1000_0000 + 32'(i));
        wait_idle("t3_idle");
        chk("t3_writes_accepted", OW'(c1_wr_acc), OW'(6));
        chk("t3_max_outstanding", OW'(max_out), '0);
        chk("t3_c1_resp_valid_seen", OW'(c1_rv_cnt), '0);
        rd(1'b0, 32'h408);
        wait_idle("t3_readback_idle");

        // Full FIFO: fifth read stalls, a concurrent write still goes through.
        step();
        c0_resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) rd(1'b0, 32'h500 + 32'(4*i));
        wait_out(4, "t4_outstanding_full");
        rd(1'b0, 32'h510);
        wr(1'b1, 32'h600, 32'hCAFE_F00D);
        @(negedge CLK);
        chk("t4_read_blocked", OW'(c0_req_ready), '0);
        chk("t4_write_accepted", OW'(c1_req_ready), OW'(1));
        step();
        c0_resp_ready = 1'b1;
        @(negedge CLK);
        chk("t4_pop_cycle_get_valid", OW'(mem_get_valid), OW'(1));
        chk("t4_no_bypass", OW'(c0_req_ready), '0);
        @(negedge CLK);
        chk("t4_out_after_pop", OW'(outstanding), OW'(3));
        chk("t4_read_accepted", OW'(c0_req_ready), OW'(1));
        wait_idle("t4_idle");

        // Response backpressure at the head goes to the right client.
        step();
        c1_resp_ready = 1'b0;
        rd(1'b1, 32'h700);
        k = 0;
        do begin @(negedge CLK); k++; end while (!c1_req_ready && k < 20);
        chk("t5_c1_accept", OW'(c1_req_ready), OW'(1));
        rd(1'b0, 32'h704);
        repeat (3) @(negedge CLK);
        chk("t5_outstanding", OW'(outstanding), OW'(2));
        chk("t5_get_valid_held", OW'(mem_get_valid), '0);
        chk("t5_c1_resp_valid", OW'(c1_resp_valid), OW'(1));
        chk("t5_c0_resp_valid", OW'(c0_resp_valid), '0);
        step();
        c1_resp_ready = 1'b1;
        @(negedge CLK);
        chk("t5_c1_resp_data", c1_resp, {4'b0000, 32'h700, 32'h700 ^ 32'h5A5A_0000});
        wait_idle("t5_idle");

        // Orphan response with an empty FIFO.
        step();
        force_orphan = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("t6_get_valid", OW'(mem_get_valid), '0);
        chk("t6_resp_valids", OW'({c0_resp_valid, c1_resp_valid}), '0);
        @(negedge CLK);
        chk("t6_err_orphan_set", OW'(err_orphan), OW'(1));
        step();
        force_orphan = 1'b0;
        repeat (2) @(negedge CLK);
        chk("t6_err_orphan_sticky", OW'(err_orphan), OW'(1));

        // Asynchronous reset with reads in flight.
        step();
        c0_resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) rd(1'b0, 32'h800 + 32'(4*i));
        wait_out(3, "t7_outstanding_3");
        #2;
        RST = 1'b1;
        c0_q.delete();
        exp_q.delete();
        wr(1'b1, 32'h900, 32'hABCD_1234);
        #1;
        chk("t7_async_outstanding", OW'(outstanding), '0);
        chk("t7_async_err_orphan", OW'(err_orphan), '0);
        chk("t7_async_get_valid", OW'(mem_get_valid), '0);
        chk("t7_async_c0_resp_valid", OW'(c0_resp_valid), '0);
        step();
        chk("t7_rst_c1_req_valid", OW'(c1_req_valid), OW'(1));
        chk("t7_rst_put_valid", OW'(mem_put_valid), '0);
        chk("t7_rst_c1_req_ready", OW'(c1_req_ready), '0);
        c0_resp_ready = 1'b1;
        RST = 1'b0;
        wait_idle("t7_write_idle");
        rd(1'b0, 32'h900);
        rd(1'b0, 32'h600);
        wait_idle("t7_read_idle");
        chk("t7_err_orphan_clear", OW'(err_orphan), '0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
